// File: rtl/config_bram_port_arbiter_if.sv
// Bus between the config-manager requesters, the port arbiter and
// BRAM_CONFIG port B. The arbiter uses the slave view; requesters and
// the BRAM use the master view.
interface config_bram_port_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0]        REQ;
  logic [NUM_REQ-1:0]        REQ_WE;
  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR;
  logic [NUM_REQ*DATA_W-1:0] REQ_DIN;
  logic [NUM_REQ-1:0]        GNT;
  logic [NUM_REQ-1:0]        RVALID;
  logic [DATA_W-1:0]         RDATA;
  logic [ADDR_W-1:0]         BRAM_ADDR;
  logic                      BRAM_WE;
  logic [DATA_W-1:0]         BRAM_DIN;
  logic [DATA_W-1:0]         BRAM_DOUT;

  modport slave (
    input  REQ, REQ_WE, REQ_ADDR, REQ_DIN, BRAM_DOUT,
    output GNT, RVALID, RDATA, BRAM_ADDR, BRAM_WE, BRAM_DIN
  );

  modport master (
    output REQ, REQ_WE, REQ_ADDR, REQ_DIN, BRAM_DOUT,
    input  GNT, RVALID, RDATA, BRAM_ADDR, BRAM_WE, BRAM_DIN
  );
endinterface

// File: rtl/config_bram_port_arbiter.sv
// Round-robin arbiter sharing BRAM_CONFIG port B among the config-manager
// requesters. One access is granted per cycle; read data is routed back to
// the originating requester by a tag pipeline matched to the BRAM latency.
module config_bram_port_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 16,
  parameter int BRAM_LATENCY = 2
) (
  input  logic                        CLK,
  input  logic                        RST,
  config_bram_port_arbiter_if.slave   bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]        ptr;
  logic [IDX_W-1:0]        win_idx;
  logic [IDX_W-1:0]        next_ptr;
  logic [IDX_W-1:0]        cand;
  int                      scan_idx;
  logic                    found;
  logic [ADDR_W-1:0]       sel_addr;
  logic [DATA_W-1:0]       sel_din;
  logic                    sel_we;
  logic [NUM_REQ-1:0]      gnt_vec;
  logic [NUM_REQ-1:0]      rvalid_vec;
  logic [BRAM_LATENCY-1:0] tag_valid;
  logic [IDX_W-1:0]        tag_idx [BRAM_LATENCY];

  // Pick the first requester at or above the pointer, wrapping; no grants during reset
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    scan_idx = 0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(ptr) + k;
      if (scan_idx >= NUM_REQ) begin
        scan_idx = scan_idx - NUM_REQ;
      end
      cand = IDX_W'(scan_idx);
      if (!found && bus.REQ[cand] && !RST) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Select the winner's command and form the grant, next pointer and return strobe
  always_comb begin
    sel_addr = '0;
    sel_din  = '0;
    sel_we   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        sel_addr = bus.REQ_ADDR[i*ADDR_W +: ADDR_W];
        sel_din  = bus.REQ_DIN[i*DATA_W +: DATA_W];
        sel_we   = bus.REQ_WE[i];
      end
    end
    gnt_vec = '0;
    if (found) begin
      gnt_vec[win_idx] = 1'b1;
    end
    next_ptr = (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + IDX_W'(1);
    rvalid_vec = '0;
    if (tag_valid[BRAM_LATENCY-1]) begin
      rvalid_vec[tag_idx[BRAM_LATENCY-1]] = 1'b1;
    end
  end

  assign bus.GNT = gnt_vec;

  // Register the BRAM command, advance the read tags and capture returning data
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr           <= '0;
      bus.BRAM_ADDR <= '0;
      bus.BRAM_WE   <= 1'b0;
      bus.BRAM_DIN  <= '0;
      bus.RVALID    <= '0;
      bus.RDATA     <= '0;
      tag_valid     <= '0;
      for (int s = 0; s < BRAM_LATENCY; s++) begin
        tag_idx[s] <= '0;
      end
    end else begin
      bus.BRAM_WE <= 1'b0;
      if (found) begin
        bus.BRAM_ADDR <= sel_addr;
        bus.BRAM_WE   <= sel_we;
        bus.BRAM_DIN  <= sel_we ? sel_din : '0;
        ptr           <= next_ptr;
      end
      tag_valid[0] <= found & ~sel_we;
      tag_idx[0]   <= win_idx;
      for (int s = 1; s < BRAM_LATENCY; s++) begin
        tag_valid[s] <= tag_valid[s-1];
        tag_idx[s]   <= tag_idx[s-1];
      end
      bus.RVALID <= rvalid_vec;
      if (tag_valid[BRAM_LATENCY-1]) begin
        bus.RDATA <= bus.BRAM_DOUT;
      end
    end
  end

endmodule

// File: tb/tb_config_bram_port_arbiter.sv
// Directed testbench for config_bram_port_arbiter with a small port-B BRAM
// model; expected values are hand-derived constants.
module tb_config_bram_port_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int ADDR_W       = 6;
  localparam int DATA_W       = 16;
  localparam int BRAM_LATENCY = 2;

  logic        CLK;
  logic        RST;
  logic        memClear;
  int          checkCount = 0;
  int          failCount  = 0;

  logic [15:0] wmem [64];
  logic [63:0] wvalid;
  logic [15:0] dout;

  config_bram_port_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  config_bram_port_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BRAM_LATENCY(BRAM_LATENCY)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  // Power-up contents: 0x13 holds 0x0003, every other address holds 0xA0nn
  function automatic logic [15:0] initVal(input logic [5:0] a);
    return (a == 6'h13) ? 16'h0003 : {8'hA0, 2'b00, a};
  endfunction

  // Free-running clock, 10 time units per cycle
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Port-B BRAM model: read-first, data one edge after the address is seen
  always @(posedge CLK) begin
    if (memClear) begin
      wvalid <= '0;
    end else if (bus.BRAM_WE) begin
      wmem[bus.BRAM_ADDR]   <= bus.BRAM_DIN;
      wvalid[bus.BRAM_ADDR] <= 1'b1;
    end
    dout <= wvalid[bus.BRAM_ADDR] ? wmem[bus.BRAM_ADDR] : initVal(bus.BRAM_ADDR);
  end

  assign bus.BRAM_DOUT = dout;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic [3:0] we,
                               input logic [23:0] addr, input logic [63:0] din);
    bus.REQ      = req;
    bus.REQ_WE   = we;
    bus.REQ_ADDR = addr;
    bus.REQ_DIN  = din;
  endtask

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  // Directed sequence; inputs change just after posedge, outputs sampled on negedge
  initial begin
    logic [3:0] expGnt;
    logic [3:0] expRv;

    RST = 1'b1;
    memClear = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 24'h0, 64'h0);

    // Reset state
    nextCycle();
    @(negedge CLK);
    checkOutput("rst_gnt",    32'(bus.GNT),       32'h0);
    checkOutput("rst_rvalid", 32'(bus.RVALID),    32'h0);
    checkOutput("rst_rdata",  32'(bus.RDATA),     32'h0);
    checkOutput("rst_addr",   32'(bus.BRAM_ADDR), 32'h0);
    checkOutput("rst_we",     32'(bus.BRAM_WE),   32'h0);
    checkOutput("rst_din",    32'(bus.BRAM_DIN),  32'h0);
    nextCycle();
    RST = 1'b0;
    memClear = 1'b0;

    // Single read by requester 0 from 0x13
    nextCycle();
    applyStimulus(4'b0001, 4'b0000, {6'h0, 6'h0, 6'h0, 6'h13}, 64'h0);
    @(negedge CLK);
    checkOutput("rd1_gnt_c0", 32'(bus.GNT), 32'h1);
    nextCycle();
    applyStimulus(4'b0000, 4'b0000, 24'h0, 64'h0);
    @(negedge CLK);
    checkOutput("rd1_gnt_c1",    32'(bus.GNT),       32'h0);
    checkOutput("rd1_addr_c1",   32'(bus.BRAM_ADDR), 32'h13);
    checkOutput("rd1_we_c1",     32'(bus.BRAM_WE),   32'h0);
    checkOutput("rd1_rvalid_c1", 32'(bus.RVALID),    32'h0);
    nextCycle();
    @(negedge CLK);
    checkOutput("rd1_rvalid_c2", 32'(bus.RVALID), 32'h0);
    nextCycle();
    @(negedge CLK);
    checkOutput("rd1_rvalid_c3", 32'(bus.RVALID), 32'h1);
    checkOutput("rd1_rdata_c3",  32'(bus.RDATA),  32'h0003);
    nextCycle();
    @(negedge CLK);
    checkOutput("rd1_rvalid_c4", 32'(bus.RVALID), 32'h0);
    checkOutput("rd1_rdata_c4",  32'(bus.RDATA),  32'h0003);

    // Short reset pulse so the pointer starts at requester 0 again
    nextCycle();
    RST = 1'b1;
    nextCycle();
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("pulse_rdata", 32'(bus.RDATA), 32'h0);

    // All four requesters reading continuously for 8 cycles
    for (int c = 0; c < 11; c++) begin
      nextCycle();
      if (c < 8) begin
        applyStimulus(4'b1111, 4'b0000, {6'h23, 6'h22, 6'h21, 6'h20}, 64'h0);
      end else begin
        applyStimulus(4'b0000, 4'b0000, 24'h0, 64'h0);
      end
      @(negedge CLK);
      expGnt = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
      expRv  = (c >= 3) ? 4'(1 << ((c - 3) % 4)) : 4'b0000;
      checkOutput($sformatf("rr_gnt_c%0d", c),    32'(bus.GNT),    32'(expGnt));
      checkOutput($sformatf("rr_rvalid_c%0d", c), 32'(bus.RVALID), 32'(expRv));
      if (c >= 3) begin
        checkOutput($sformatf("rr_rdata_c%0d", c), 32'(bus.RDATA), 32'h0000A020 + 32'((c - 3) % 4));
      end
    end

    // Requester 2 writes 0x00AB to 0x01, requester 0 reads it back next cycle
    nextCycle();
    applyStimulus(4'b0100, 4'b0100, {6'h0, 6'h01, 6'h0, 6'h0}, {16'h0, 16'h00AB, 16'h0, 16'h0});
    @(negedge CLK);
    checkOutput("wr_gnt_c0", 32'(bus.GNT), 32'h4);
    nextCycle();
    applyStimulus(4'b0001, 4'b0000, {6'h0, 6'h0, 6'h0, 6'h01}, 64'h0);
    @(negedge CLK);
    checkOutput("wr_gnt_c1",  32'(bus.GNT),       32'h1);
    checkOutput("wr_we_c1",   32'(bus.BRAM_WE),   32'h1);
    checkOutput("wr_din_c1",  32'(bus.BRAM_DIN),  32'h00AB);
    checkOutput("wr_addr_c1", 32'(bus.BRAM_ADDR), 32'h01);
    nextCycle();
    applyStimulus(4'b0000, 4'b0000, 24'h0, 64'h0);
    @(negedge CLK);
    checkOutput("wr_we_c2",   32'(bus.BRAM_WE),   32'h0);
    checkOutput("wr_addr_c2", 32'(bus.BRAM_ADDR), 32'h01);
    checkOutput("wr_din_c2",  32'(bus.BRAM_DIN),  32'h0);
    nextCycle();
    @(negedge CLK);
    checkOutput("wr_rvalid_c3", 32'(bus.RVALID), 32'h0);
    nextCycle();
    @(negedge CLK);
    checkOutput("wr_rvalid_c4", 32'(bus.RVALID), 32'h1);
    checkOutput("wr_rdata_c4",  32'(bus.RDATA),  32'h00AB);

    // Reads by requesters 1 and 3, then reset while both are in flight
    nextCycle();
    applyStimulus(4'b1010, 4'b0000, {6'h31, 6'h0, 6'h30, 6'h0}, 64'h0);
    @(negedge CLK);
    checkOutput("mr_gnt_c0", 32'(bus.GNT), 32'h2);
    nextCycle();
    applyStimulus(4'b1000, 4'b0000, {6'h31, 6'h0, 6'h30, 6'h0}, 64'h0);
    @(negedge CLK);
    checkOutput("mr_gnt_c1",  32'(bus.GNT),       32'h8);
    checkOutput("mr_addr_c1", 32'(bus.BRAM_ADDR), 32'h30);
    nextCycle();
    RST = 1'b1;
    applyStimulus(4'b0010, 4'b0000, {6'h31, 6'h0, 6'h30, 6'h0}, 64'h0);
    @(negedge CLK);
    checkOutput("mr_gnt_c2", 32'(bus.GNT), 32'h0);
    nextCycle();
    RST = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 24'h0, 64'h0);
    @(negedge CLK);
    checkOutput("mr_rvalid_c3", 32'(bus.RVALID),    32'h0);
    checkOutput("mr_we_c3",     32'(bus.BRAM_WE),   32'h0);
    checkOutput("mr_addr_c3",   32'(bus.BRAM_ADDR), 32'h0);
    checkOutput("mr_rdata_c3",  32'(bus.RDATA),     32'h0);
    nextCycle();
    @(negedge CLK);
    checkOutput("mr_rvalid_c4", 32'(bus.RVALID), 32'h0);
    nextCycle();
    applyStimulus(4'b1010, 4'b0000, {6'h31, 6'h0, 6'h30, 6'h0}, 64'h0);
    @(negedge CLK);
    checkOutput("mr_gnt_c5",    32'(bus.GNT),    32'h2);
    checkOutput("mr_rvalid_c5", 32'(bus.RVALID), 32'h0);
    nextCycle();
    applyStimulus(4'b0000, 4'b0000, 24'h0, 64'h0);
    @(negedge CLK);
    checkOutput("mr_addr_c6", 32'(bus.BRAM_ADDR), 32'h30);
    nextCycle();
    nextCycle();
    @(negedge CLK);
    checkOutput("mr_rvalid_c8", 32'(bus.RVALID), 32'h2);
    checkOutput("mr_rdata_c8",  32'(bus.RDATA),  32'hA030);

    // Requester 3 writes 0x1234 to 0x05, then five idle cycles
    nextCycle();
    applyStimulus(4'b1000, 4'b1000, {6'h05, 6'h0, 6'h0, 6'h0}, {16'h1234, 48'h0});
    @(negedge CLK);
    checkOutput("idle_gnt_c0", 32'(bus.GNT), 32'h8);
    nextCycle();
    applyStimulus(4'b0000, 4'b0000, 24'h0, 64'h0);
    @(negedge CLK);
    checkOutput("idle_we_c1",   32'(bus.BRAM_WE),   32'h1);
    checkOutput("idle_addr_c1", 32'(bus.BRAM_ADDR), 32'h05);
    checkOutput("idle_din_c1",  32'(bus.BRAM_DIN),  32'h1234);
    for (int c = 2; c < 7; c++) begin
      nextCycle();
      @(negedge CLK);
      checkOutput($sformatf("idle_we_c%0d", c),     32'(bus.BRAM_WE),   32'h0);
      checkOutput($sformatf("idle_addr_c%0d", c),   32'(bus.BRAM_ADDR), 32'h05);
      checkOutput($sformatf("idle_gnt_c%0d", c),    32'(bus.GNT),       32'h0);
      checkOutput($sformatf("idle_rvalid_c%0d", c), 32'(bus.RVALID),    32'h0);
    end

    // Requester 0 keeps re-requesting while requester 2 waits: grants alternate
    for (int c = 0; c < 8; c++) begin
      nextCycle();
      if (c < 4) begin
        applyStimulus(4'b0101, 4'b0000, {6'h0, 6'h09, 6'h0, 6'h07}, 64'h0);
      end else begin
        applyStimulus(4'b0000, 4'b0000, 24'h0, 64'h0);
      end
      @(negedge CLK);
      expGnt = (c < 4) ? ((c % 2 == 0) ? 4'b0001 : 4'b0100) : 4'b0000;
      expRv  = (c >= 3 && c < 7) ? (((c - 3) % 2 == 0) ? 4'b0001 : 4'b0100) : 4'b0000;
      checkOutput($sformatf("alt_gnt_c%0d", c),    32'(bus.GNT),    32'(expGnt));
      checkOutput($sformatf("alt_rvalid_c%0d", c), 32'(bus.RVALID), 32'(expRv));
      if (c >= 3 && c < 7) begin
        checkOutput($sformatf("alt_rdata_c%0d", c), 32'(bus.RDATA),
                    ((c - 3) % 2 == 0) ? 32'hA007 : 32'hA009);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
